// File: rtl/sap1_pkg.sv
// Shared SAP-1 run-control definitions: controller states, T-state one-hot codes, opcodes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sap1_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRIME     = 3'd1,
        ST_RUN       = 3'd2,
        ST_STEP_WAIT = 3'd3,
        ST_HALT      = 3'd4
    } state_t;

    // One-hot ring counter codes from the SAP-1 control sequencer
    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    // Instruction register upper-nibble opcodes
    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

endpackage

// File: rtl/sap1_run_ctrl.sv
// SAP-1 run controller: program load, clear priming, run, HLT/watchdog stop (optional single-step via SAP1_STEP_EN).
// Latency: RAM write is combinational in the accepting IDLE cycle; state/flags update on the next rising edge.
// Backpressure: ld_ready is high only in IDLE; bytes offered in any other state (or during clr) are not written.
module sap1_run_ctrl
    import sap1_pkg::*;
#(
    parameter int CLR_CYCLES = 6,
    parameter int MAX_INSTR  = 200
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       ld_valid,
    output logic       ld_ready,
    input  logic [3:0] ld_addr,
    input  logic [7:0] ld_data,
    input  logic       start,
    input  logic       step_mode,
    input  logic       step,
    input  logic [5:0] ring_t,
    input  logic [3:0] opcode,
    output logic       ram_we,
    output logic [3:0] ram_addr,
    output logic [7:0] ram_wdata,
    output logic       cpu_clr,
    output logic       cpu_clk_en,
    output logic       halted,
    output logic       timeout,
    output logic [7:0] instr_cnt
);

    localparam logic [3:0] CLR_LAST = 4'(CLR_CYCLES - 1);
    localparam logic [7:0] MAX_CNT  = 8'(MAX_INSTR);

    state_t     state_q, state_d;
    logic [3:0] prime_cnt_q, prime_cnt_d;
    logic [7:0] instr_cnt_q, instr_cnt_d;
    logic       halted_q, halted_d;
    logic       timeout_q, timeout_d;

    // T-states are decoded bit-wise so a malformed ring pattern with both T4 and T6
    // set still resolves deterministically (HLT beats the watchdog).
    logic       t4_hit;
    logic       t6_hit;
    logic [7:0] cnt_inc;

`ifndef SAP1_STEP_EN
    // Step inputs stay on the port list but have no effect in this build
    logic unused_step;
    assign unused_step = step ^ step_mode;
`endif

    // Next-state, counters and all outputs for the run-control FSM
    always_comb begin
        state_d     = state_q;
        prime_cnt_d = prime_cnt_q;
        instr_cnt_d = instr_cnt_q;
        halted_d    = halted_q;
        timeout_d   = timeout_q;
        ld_ready    = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = 4'h0;
        ram_wdata   = 8'h00;
        cpu_clr     = 1'b0;
        cpu_clk_en  = 1'b0;
        t4_hit      = |(ring_t & T4);
        t6_hit      = |(ring_t & T6);
        cnt_inc     = (instr_cnt_q == 8'hFF) ? 8'hFF : instr_cnt_q + 8'd1;

        case (state_q)
            ST_IDLE: begin
                ld_ready = 1'b1;
                cpu_clr  = 1'b1;
                if (ld_valid) begin
                    // A byte offered while clr is high is dropped; the write still wins over start
                    if (!clr) begin
                        ram_we    = 1'b1;
                        ram_addr  = ld_addr;
                        ram_wdata = ld_data;
                    end
                end else if (start) begin
                    state_d     = ST_PRIME;
                    prime_cnt_d = 4'd0;
                    instr_cnt_d = 8'd0;
                    halted_d    = 1'b0;
                    timeout_d   = 1'b0;
                end
            end
            ST_PRIME: begin
                cpu_clr    = 1'b1;
                cpu_clk_en = 1'b1;
                if (prime_cnt_q == CLR_LAST) begin
                    state_d     = ST_RUN;
                    prime_cnt_d = 4'd0;
                end else begin
                    prime_cnt_d = prime_cnt_q + 4'd1;
                end
            end
            ST_RUN: begin
                cpu_clk_en = 1'b1;
                if (t6_hit) begin
                    instr_cnt_d = cnt_inc;
                end
                if (t4_hit && (opcode == OP_HLT)) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end else if (t6_hit && (cnt_inc == MAX_CNT)) begin
                    state_d   = ST_HALT;
                    timeout_d = 1'b1;
                end
`ifdef SAP1_STEP_EN
                else if (t6_hit && step_mode) begin
                    state_d = ST_STEP_WAIT;
                end
`endif
            end
            ST_STEP_WAIT: begin
`ifdef SAP1_STEP_EN
                if (step) begin
                    state_d = ST_RUN;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_HALT: begin
                if (start) begin
                    state_d     = ST_PRIME;
                    prime_cnt_d = 4'd0;
                    instr_cnt_d = 8'd0;
                    halted_d    = 1'b0;
                    timeout_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous clear
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            prime_cnt_q <= 4'd0;
            instr_cnt_q <= 8'd0;
            halted_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prime_cnt_q <= prime_cnt_d;
            instr_cnt_q <= instr_cnt_d;
            halted_q    <= halted_d;
            timeout_q   <= timeout_d;
        end
    end

    assign halted    = halted_q;
    assign timeout   = timeout_q;
    assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_sap1_run_ctrl.sv
// Self-checking bench for sap1_run_ctrl: directed scenarios plus randomized runs against a cycle reference.
// Latency: inputs change 1 time unit after each rising edge; outputs are sampled there as well.
// Backpressure: exercises ld_valid in every state to confirm writes only land in IDLE.
module tb_sap1_run_ctrl;
    import sap1_pkg::*;

    localparam int CLR  = 6;
    localparam int MAXI = 3;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       ld_valid = 1'b0;
    logic       ld_ready;
    logic [3:0] ld_addr = 4'h0;
    logic [7:0] ld_data = 8'h00;
    logic       start = 1'b0;
    logic       step_mode = 1'b0;
    logic       step = 1'b0;
    logic [5:0] ring_t = 6'h00;
    logic [3:0] opcode = 4'h0;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       cpu_clr;
    logic       cpu_clk_en;
    logic       halted;
    logic       timeout;
    logic [7:0] instr_cnt;

    int n_checks = 0;
    int n_errors = 0;

    sap1_run_ctrl #(.CLR_CYCLES(CLR), .MAX_INSTR(MAXI)) dut (
        .clk(clk), .clr(clr), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_addr(ld_addr), .ld_data(ld_data), .start(start),
        .step_mode(step_mode), .step(step), .ring_t(ring_t), .opcode(opcode),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .cpu_clr(cpu_clr), .cpu_clk_en(cpu_clk_en), .halted(halted),
        .timeout(timeout), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        clr = 1'b1; ld_valid = 1'b0; start = 1'b0; step = 1'b0; step_mode = 1'b0;
        ring_t = 6'h00; opcode = 4'h0;
        tick; tick;
        clr = 1'b0;
        #1;
    endtask

    // Issue start from IDLE/HALT and measure how many cycles the CPU is held in clear while clocked
    task automatic start_run(output int prime_len);
        start = 1'b1; tick; start = 1'b0;
        prime_len = 0;
        for (int k = 0; k < 40; k++) begin
            if (cpu_clr && cpu_clk_en) begin
                prime_len++;
                tick;
            end else begin
                break;
            end
        end
    endtask

    task automatic run_instr(input logic [3:0] op);
        for (int t = 0; t < 6; t++) begin
            ring_t = 6'(1 << t); opcode = op; tick;
        end
        ring_t = T1;
    endtask

    task automatic test_reset;
        clr = 1'b1; ld_valid = 1'b1; ld_addr = 4'h7; ld_data = 8'h55;
        #1;
        n_checks++; if (ram_we !== 1'b0) begin n_errors++; $display("FAIL reset_byte_dropped ram_we got %b exp 0", ram_we); end
        tick; tick;
        clr = 1'b0; ld_valid = 1'b0;
        #1;
        n_checks++; if (ld_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ld_ready got %b exp 1", ld_ready); end
        n_checks++; if (ram_we !== 1'b0) begin n_errors++; $display("FAIL reset_ram_we got %b exp 0", ram_we); end
        n_checks++; if (ram_addr !== 4'h0 || ram_wdata !== 8'h00) begin n_errors++; $display("FAIL reset_ram_bus got %h/%h exp 0/00", ram_addr, ram_wdata); end
        n_checks++; if (cpu_clr !== 1'b1 || cpu_clk_en !== 1'b0) begin n_errors++; $display("FAIL reset_cpu_ctl got clr=%b en=%b exp 1/0", cpu_clr, cpu_clk_en); end
        n_checks++; if (halted !== 1'b0 || timeout !== 1'b0) begin n_errors++; $display("FAIL reset_flags got h=%b t=%b exp 0/0", halted, timeout); end
        n_checks++; if (instr_cnt !== 8'd0) begin n_errors++; $display("FAIL reset_instr_cnt got %0d exp 0", instr_cnt); end
        // Reset in the middle of PRIME returns to IDLE and stays there
        start = 1'b1; tick; start = 1'b0; tick; tick;
        n_checks++; if (cpu_clk_en !== 1'b1 || cpu_clr !== 1'b1) begin n_errors++; $display("FAIL prime_entered got clr=%b en=%b exp 1/1", cpu_clr, cpu_clk_en); end
        clr = 1'b1; tick; clr = 1'b0;
        for (int k = 0; k < 10; k++) tick;
        n_checks++; if (cpu_clk_en !== 1'b0 || cpu_clr !== 1'b1 || ld_ready !== 1'b1) begin n_errors++; $display("FAIL reset_mid_prime got clr=%b en=%b rdy=%b exp 1/0/1", cpu_clr, cpu_clk_en, ld_ready); end
    endtask

    task automatic test_load;
        logic [7:0] prog [3];
        int pulses;
        prog[0] = 8'h09; prog[1] = 8'h1A; prog[2] = 8'hF0;
        pulses = 0;
        do_reset;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_addr = 4'(i); ld_data = prog[i];
            #1;
            if (ram_we === 1'b1) pulses++;
            n_checks++; if (ram_addr !== 4'(i) || ram_wdata !== prog[i]) begin n_errors++; $display("FAIL load_bus[%0d] got %h/%h exp %h/%h", i, ram_addr, ram_wdata, 4'(i), prog[i]); end
            n_checks++; if (ld_ready !== 1'b1) begin n_errors++; $display("FAIL load_ready[%0d] got %b exp 1", i, ld_ready); end
            tick;
        end
        ld_valid = 1'b0;
        #1;
        n_checks++; if (pulses != 3) begin n_errors++; $display("FAIL load_pulses got %0d exp 3", pulses); end
        n_checks++; if (ram_we !== 1'b0) begin n_errors++; $display("FAIL load_idle_we got %b exp 0", ram_we); end
    endtask

    task automatic test_run_hlt;
        int plen;
        do_reset;
        start_run(plen);
        n_checks++; if (plen != CLR) begin n_errors++; $display("FAIL prime_len got %0d exp %0d", plen, CLR); end
        run_instr(OP_LDA);
        run_instr(OP_ADD);
        for (int t = 0; t < 3; t++) begin ring_t = 6'(1 << t); opcode = OP_LDA; tick; end
        ring_t = T4; opcode = OP_HLT;
        #1;
        n_checks++; if (halted !== 1'b0 || cpu_clk_en !== 1'b1) begin n_errors++; $display("FAIL hlt_before got h=%b en=%b exp 0/1", halted, cpu_clk_en); end
        tick;
        n_checks++; if (halted !== 1'b1 || timeout !== 1'b0) begin n_errors++; $display("FAIL hlt_flags got h=%b t=%b exp 1/0", halted, timeout); end
        n_checks++; if (cpu_clk_en !== 1'b0 || cpu_clr !== 1'b0) begin n_errors++; $display("FAIL hlt_cpu_ctl got en=%b clr=%b exp 0/0", cpu_clk_en, cpu_clr); end
        n_checks++; if (instr_cnt !== 8'd2) begin n_errors++; $display("FAIL hlt_instr_cnt got %0d exp 2", instr_cnt); end
        ring_t = T6; opcode = OP_LDA; tick; tick;
        n_checks++; if (instr_cnt !== 8'd2 || halted !== 1'b1) begin n_errors++; $display("FAIL hlt_hold got cnt=%0d h=%b exp 2/1", instr_cnt, halted); end
    endtask

    task automatic test_watchdog;
        int plen;
        do_reset;
        start_run(plen);
        for (int n = 1; n <= MAXI; n++) begin
            for (int t = 0; t < 6; t++) begin
                ring_t = 6'(1 << t); opcode = OP_LDA;
                if (n == MAXI && t == 5) begin
                    #1;
                    n_checks++; if (timeout !== 1'b0) begin n_errors++; $display("FAIL wd_early got %b exp 0", timeout); end
                end
                tick;
            end
        end
        n_checks++; if (timeout !== 1'b1 || halted !== 1'b0) begin n_errors++; $display("FAIL wd_flags got t=%b h=%b exp 1/0", timeout, halted); end
        n_checks++; if (cpu_clk_en !== 1'b0 || instr_cnt !== 8'(MAXI)) begin n_errors++; $display("FAIL wd_state got en=%b cnt=%0d exp 0/%0d", cpu_clk_en, instr_cnt, MAXI); end
        ld_valid = 1'b1; ld_addr = 4'h3; ld_data = 8'hAA;
        #1;
        n_checks++; if (ram_we !== 1'b0 || ld_ready !== 1'b0) begin n_errors++; $display("FAIL halt_no_write got we=%b rdy=%b exp 0/0", ram_we, ld_ready); end
        ld_valid = 1'b0;
    endtask

    task automatic test_priority;
        int plen;
        do_reset;
        start = 1'b1; ld_valid = 1'b1; ld_addr = 4'h5; ld_data = 8'hA5;
        #1;
        n_checks++; if (ram_we !== 1'b1 || ram_addr !== 4'h5 || ram_wdata !== 8'hA5) begin n_errors++; $display("FAIL prio_write got we=%b %h/%h exp 1 5/a5", ram_we, ram_addr, ram_wdata); end
        tick;
        start = 1'b0; ld_valid = 1'b0;
        #1;
        n_checks++; if (cpu_clk_en !== 1'b0 || ld_ready !== 1'b1) begin n_errors++; $display("FAIL prio_stay_idle got en=%b rdy=%b exp 0/1", cpu_clk_en, ld_ready); end
        start_run(plen);
        run_instr(OP_LDA);
        run_instr(OP_SUB);
        ring_t = T4 | T6; opcode = OP_HLT; tick;
        n_checks++; if (halted !== 1'b1 || timeout !== 1'b0) begin n_errors++; $display("FAIL prio_hlt_wd got h=%b t=%b exp 1/0", halted, timeout); end
        n_checks++; if (instr_cnt !== 8'd3) begin n_errors++; $display("FAIL prio_cnt got %0d exp 3", instr_cnt); end
        // Rerun from HALT clears flags and count
        ring_t = T1; start = 1'b1; tick; start = 1'b0;
        n_checks++; if (halted !== 1'b0 || timeout !== 1'b0 || instr_cnt !== 8'd0) begin n_errors++; $display("FAIL rerun_clear got h=%b t=%b cnt=%0d exp 0/0/0", halted, timeout, instr_cnt); end
        n_checks++; if (cpu_clr !== 1'b1 || cpu_clk_en !== 1'b1) begin n_errors++; $display("FAIL rerun_prime got clr=%b en=%b exp 1/1", cpu_clr, cpu_clk_en); end
    endtask

    task automatic test_reset_midrun;
        int plen;
        do_reset;
        start_run(plen);
        run_instr(OP_ADD);
        n_checks++; if (instr_cnt !== 8'd1) begin n_errors++; $display("FAIL midrun_cnt got %0d exp 1", instr_cnt); end
        ring_t = T2; clr = 1'b1; ld_valid = 1'b1; ld_addr = 4'h9; ld_data = 8'h3C;
        #1;
        n_checks++; if (ram_we !== 1'b0) begin n_errors++; $display("FAIL midrun_clr_we got %b exp 0", ram_we); end
        tick;
        clr = 1'b0; ld_valid = 1'b0;
        #1;
        n_checks++; if (ld_ready !== 1'b1 || cpu_clr !== 1'b1 || cpu_clk_en !== 1'b0) begin n_errors++; $display("FAIL midrun_idle got rdy=%b clr=%b en=%b exp 1/1/0", ld_ready, cpu_clr, cpu_clk_en); end
        n_checks++; if (instr_cnt !== 8'd0 || halted !== 1'b0 || timeout !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 4'h0 || ram_wdata !== 8'h00) begin
            n_errors++; $display("FAIL midrun_values got cnt=%0d h=%b t=%b we=%b %h/%h exp all zero", instr_cnt, halted, timeout, ram_we, ram_addr, ram_wdata);
        end
    endtask

    task automatic test_step;
        int plen;
        do_reset;
        step_mode = 1'b1;
        start_run(plen);
        run_instr(OP_LDA);
`ifdef SAP1_STEP_EN
        n_checks++; if (cpu_clk_en !== 1'b0 || instr_cnt !== 8'd1) begin n_errors++; $display("FAIL step_wait1 got en=%b cnt=%0d exp 0/1", cpu_clk_en, instr_cnt); end
        tick; tick; tick;
        n_checks++; if (cpu_clk_en !== 1'b0 || instr_cnt !== 8'd1) begin n_errors++; $display("FAIL step_hold got en=%b cnt=%0d exp 0/1", cpu_clk_en, instr_cnt); end
        step = 1'b1; tick; step = 1'b0;
        n_checks++; if (cpu_clk_en !== 1'b1) begin n_errors++; $display("FAIL step_release got %b exp 1", cpu_clk_en); end
        run_instr(OP_OUT);
        n_checks++; if (cpu_clk_en !== 1'b0 || instr_cnt !== 8'd2) begin n_errors++; $display("FAIL step_wait2 got en=%b cnt=%0d exp 0/2", cpu_clk_en, instr_cnt); end
`else
        n_checks++; if (cpu_clk_en !== 1'b1 || instr_cnt !== 8'd1) begin n_errors++; $display("FAIL step_ignored got en=%b cnt=%0d exp 1/1", cpu_clk_en, instr_cnt); end
        step = 1'b1; tick; step = 1'b0;
        n_checks++; if (cpu_clk_en !== 1'b1 || halted !== 1'b0) begin n_errors++; $display("FAIL step_pulse_ignored got en=%b h=%b exp 1/0", cpu_clk_en, halted); end
`endif
        step_mode = 1'b0;
    endtask

    // Random T-state/opcode streams; reference tracks count of completed instructions and the first stop event
    task automatic test_random;
        int plen;
        int m_cnt;
        logic m_stop, m_h, m_to;
        logic [5:0] rt;
        logic [3:0] op;
        for (int it = 0; it < 8; it++) begin
            do_reset;
            start_run(plen);
            n_checks++; if (plen != CLR) begin n_errors++; $display("FAIL rnd_prime[%0d] got %0d exp %0d", it, plen, CLR); end
            m_cnt = 0; m_stop = 1'b0; m_h = 1'b0; m_to = 1'b0;
            for (int c = 0; c < 30; c++) begin
                rt = 6'(1 << $urandom_range(0, 5));
                case ($urandom_range(0, 4))
                    0: op = OP_LDA;
                    1: op = OP_ADD;
                    2: op = OP_SUB;
                    3: op = OP_OUT;
                    default: op = OP_HLT;
                endcase
                ring_t = rt; opcode = op;
                ld_valid = 1'($urandom_range(0, 1)); ld_addr = 4'($urandom); ld_data = 8'($urandom);
`ifndef SAP1_STEP_EN
                step_mode = 1'($urandom_range(0, 1)); step = 1'($urandom_range(0, 1));
`endif
                #1;
                n_checks++; if (ram_we !== 1'b0 || ld_ready !== 1'b0) begin n_errors++; $display("FAIL rnd_no_write[%0d.%0d] got we=%b rdy=%b exp 0/0", it, c, ram_we, ld_ready); end
                if (!m_stop) begin
                    if (rt == T6) m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
                    if (rt == T4 && op == OP_HLT) begin
                        m_stop = 1'b1; m_h = 1'b1;
                    end else if (rt == T6 && m_cnt == MAXI) begin
                        m_stop = 1'b1; m_to = 1'b1;
                    end
                end
                tick;
                n_checks++;
                if (instr_cnt !== 8'(m_cnt) || halted !== m_h || timeout !== m_to || cpu_clk_en !== !m_stop) begin
                    n_errors++;
                    $display("FAIL rnd_state[%0d.%0d] got cnt=%0d h=%b t=%b en=%b exp %0d/%b/%b/%b", it, c, instr_cnt, halted, timeout, cpu_clk_en, m_cnt, m_h, m_to, !m_stop);
                end
            end
            ld_valid = 1'b0; step_mode = 1'b0; step = 1'b0;
        end
    endtask

    initial begin
        test_reset;
        test_load;
        test_run_hlt;
        test_watchdog;
        test_priority;
        test_reset_midrun;
        test_step;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
